// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Mirrors the shared defines used across the core (instruction NOP,
// zero word, enable levels, bus widths) plus the fetch buffer entry type.
package inst_fetch_pkg;

  localparam logic [31:0] INST_NOP    = 32'h0000_0001;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        RstEnable   = 1'b1;
  localparam logic        JumpEnable  = 1'b1;
  localparam logic        HoldEnable  = 1'b1;
  localparam int          SramBus     = 32;
  localparam int          SramAddrBus = 32;

  // One buffered fetch result: the address it was fetched from and the word.
  typedef struct packed {
    logic [SramAddrBus-1:0] addr;
    logic [SramBus-1:0]     inst;
  } fetch_entry_t;

  // Sequential fetch address; 32-bit arithmetic wraps FFFF_FFFC -> 0.
  function automatic logic [SramAddrBus-1:0] next_word(input logic [SramAddrBus-1:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, used for the fetch data buffer and
// for the in-flight request address queue. DEPTH must be a power of two
// so the read/write pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next-state; flush empties the FIFO.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates their use.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, issues word requests on the
// instruction bus, buffers responses in order and presents one
// instruction per cycle to if_id. Redirects (interrupt over jump) clear
// the buffer and drop responses to requests issued before the redirect.
// Optional build macro IFU_BYPASS_EN: a response arriving while the
// buffer is empty is shown on inst_o in the same cycle.
//
// Bus handshake: ibus_req_o/ibus_addr_o form a request that is
// transferred on a cycle where ibus_req_o && ibus_gnt_i; while ungranted
// the address is held (a redirect or debug halt may withdraw it).
// ibus_rvalid_i returns one response per granted request, in order, at
// least one cycle after its grant; there is no back-pressure on
// responses because the issue cap always leaves room for them.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jump_flag_i,
  input  logic [SramAddrBus-1:0] jump_addr_i,
  input  logic                   int_flag_i,
  input  logic [SramAddrBus-1:0] int_addr_i,
  input  logic                   hold_flag_i,
  input  logic                   dm_halt_req_i,
  output logic                   ibus_req_o,
  output logic [SramAddrBus-1:0] ibus_addr_o,
  input  logic                   ibus_gnt_i,
  input  logic                   ibus_rvalid_i,
  input  logic [SramBus-1:0]     ibus_rdata_i,
  output logic [SramBus-1:0]     inst_o,
  output logic [SramAddrBus-1:0] inst_addr_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [SramAddrBus-1:0] pc_q, pc_d;
  logic [CW-1:0]          discard_q, discard_d;

  logic                   flush, hold, halt, issue, keep, consume_ok;
  logic [SramAddrBus-1:0] redirect_addr;
  logic [CW:0]            inflight;

  // Address queue: one entry per outstanding request; its count is the
  // outstanding counter.
  logic                   aq_full, aq_empty;
  logic [CW-1:0]          aq_count;
  logic [SramAddrBus-1:0] aq_head;

  // Data FIFO of {addr, inst}.
  logic                   df_push, df_pop, df_full, df_empty;
  logic [CW-1:0]          df_count;
  fetch_entry_t           df_head, df_wdata, out_entry;
  logic                   out_valid;

  // Redirect, stall and issue decisions for this cycle.
  always_comb begin
    flush         = int_flag_i || (jump_flag_i == JumpEnable);
    redirect_addr = int_flag_i ? int_addr_i : jump_addr_i;
    hold          = (hold_flag_i == HoldEnable);
    halt          = dm_halt_req_i;
    inflight      = {1'b0, aq_count} + {1'b0, df_count};
    ibus_req_o    = (rst != RstEnable) && !flush && !halt && !aq_full &&
                    (inflight < (CW+1)'(FIFO_DEPTH));
    ibus_addr_o   = (rst == RstEnable) ? RESET_PC : pc_q;
    issue         = ibus_req_o && ibus_gnt_i;
    keep          = ibus_rvalid_i && !flush && (discard_q == '0);
    consume_ok    = !hold && !halt && !flush;
    df_wdata.addr = aq_head;
    df_wdata.inst = ibus_rdata_i;
  end

`ifdef IFU_BYPASS_EN
  // Empty buffer: show a kept response immediately; store it only if if_id
  // cannot take it this cycle.
  always_comb begin
    df_pop    = !df_empty && consume_ok;
    df_push   = keep && !(df_empty && consume_ok) && (!df_full || df_pop);
    out_valid = !df_empty || keep;
    out_entry = df_empty ? df_wdata : df_head;
  end
`else
  // All responses pass through the buffer; the head is presented next cycle.
  always_comb begin
    df_pop    = !df_empty && consume_ok;
    df_push   = keep && (!df_full || df_pop);
    out_valid = !df_empty;
    out_entry = df_head;
  end
`endif

  // Output to if_id: NOP/zero when nothing to present, halted or in reset.
  always_comb begin
    inst_o      = INST_NOP;
    inst_addr_o = ZeroWord;
    if ((rst != RstEnable) && !halt && out_valid) begin
      inst_o      = out_entry.inst;
      inst_addr_o = out_entry.addr;
    end
  end

  // PC and discard counter next-state.
  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q;
    if (issue) pc_d = next_word(pc_q);
    if (flush) begin
      pc_d      = redirect_addr;
      // Everything still in flight belongs to the old stream; a response
      // landing in this very cycle is already being dropped.
      discard_d = aq_count - CW'(ibus_rvalid_i);
    end else if (ibus_rvalid_i && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
  end

  // PC and discard counter registers.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  // In-flight addresses; never flushed so dropped responses still retire them.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SramAddrBus)
  ) u_addr_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (1'b0),
    .push_i  (issue),
    .wdata_i (pc_q),
    .pop_i   (ibus_rvalid_i && !aq_empty),
    .rdata_o (aq_head),
    .full_o  (aq_full),
    .empty_o (aq_empty),
    .count_o (aq_count)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_data_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (df_push),
    .wdata_i (df_wdata),
    .pop_i   (df_pop),
    .rdata_o (df_head),
    .full_o  (df_full),
    .empty_o (df_empty),
    .count_o (df_count)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by a randomized run.
// An in-bench bus model returns mem_word(addr) in order after a random
// latency; the reference model tracks the program-order address streams
// (issued and consumed), which restart at the redirect target.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] NOP        = 32'h0000_0001;
  localparam int          IDLE_MAX   = 40;
`ifdef IFU_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i, int_flag_i, hold_flag_i, dm_halt_req_i;
  logic [31:0] jump_addr_i, int_addr_i;
  logic        ibus_req_o, ibus_gnt_i, ibus_rvalid_i;
  logic [31:0] ibus_addr_o, ibus_rdata_i, inst_o, inst_addr_o;

  inst_fetch #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .int_flag_i    (int_flag_i),
    .int_addr_i    (int_addr_i),
    .hold_flag_i   (hold_flag_i),
    .dm_halt_req_i (dm_halt_req_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o)
  );

  // Clock
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          gnt_pct, lat_min, lat_max, last_due, idle_cnt;
  logic [31:0] bus_addr_q[$];
  int          bus_due_q[$];
  logic [31:0] exp_issue, exp_cons;
  logic [31:0] cons_log[$];
  logic        prev_wait;
  logic [31:0] prev_addr;
  logic        s_req;
  logic [31:0] s_addr, s_inst, s_iaddr;

  // Memory image: word 0 is a real instruction, others are address-derived.
  // Bits [1:0] are always 11, so no word ever equals NOP.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return (a ^ 32'h5A5A_0000) | 32'h3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the bus, sample mid-cycle, check, advance model.
  task automatic step();
    logic        flush_now, consumed;
    logic [31:0] tgt;
    int          due;
    ibus_gnt_i = ($urandom_range(99) < gnt_pct);
    if (bus_addr_q.size() > 0 && bus_due_q[0] <= cyc) begin
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i  = mem_word(bus_addr_q[0]);
    end else begin
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = $urandom;
    end
    #4;
    s_req   = ibus_req_o;
    s_addr  = ibus_addr_o;
    s_inst  = inst_o;
    s_iaddr = inst_addr_o;
    flush_now = int_flag_i | jump_flag_i;
    tgt       = int_flag_i ? int_addr_i : jump_addr_i;
    if (rst) begin
      chk("rst_req", 32'(s_req), 32'd0);
      chk("rst_addr", s_addr, RESET_PC);
      chk("rst_inst", s_inst, NOP);
      chk("rst_inst_addr", s_iaddr, 32'h0);
      bus_addr_q.delete();
      bus_due_q.delete();
      last_due  = cyc + 1;
      exp_issue = RESET_PC;
      exp_cons  = RESET_PC;
      prev_wait = 1'b0;
      idle_cnt  = 0;
    end else begin
      if (ibus_rvalid_i) begin
        void'(bus_addr_q.pop_front());
        void'(bus_due_q.pop_front());
      end
      if (flush_now) chk("no_req_in_flush", 32'(s_req), 32'd0);
      if (prev_wait && !flush_now && !dm_halt_req_i) begin
        chk("req_held", 32'(s_req), 32'd1);
        chk("addr_held", s_addr, prev_addr);
      end
      if (s_req && ibus_gnt_i) begin
        chk("issue_addr", s_addr, exp_issue);
        exp_issue = exp_issue + 32'd4;
        due = cyc + 1 + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        bus_addr_q.push_back(s_addr);
        bus_due_q.push_back(due);
        chk("issue_cap", 32'(bus_addr_q.size() <= FIFO_DEPTH), 32'd1);
      end
      if (dm_halt_req_i) begin
        chk("halt_inst", s_inst, NOP);
        chk("halt_inst_addr", s_iaddr, 32'h0);
      end
      consumed = (s_inst != NOP) && !hold_flag_i && !dm_halt_req_i && !flush_now;
      if (consumed) begin
        chk("cons_addr", s_iaddr, exp_cons);
        chk("cons_inst", s_inst, mem_word(exp_cons));
        cons_log.push_back(s_iaddr);
        exp_cons = exp_cons + 32'd4;
        idle_cnt = 0;
      end else if (!hold_flag_i && !dm_halt_req_i) begin
        idle_cnt++;
      end
      if (idle_cnt > IDLE_MAX) begin
        chk("progress_stall", 32'(idle_cnt), 32'd0);
        idle_cnt = 0;
      end
      if (flush_now) begin
        exp_issue = tgt;
        exp_cons  = tgt;
        idle_cnt  = 0;
      end
      prev_wait = s_req && !ibus_gnt_i && !flush_now && !dm_halt_req_i;
      prev_addr = s_addr;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int          halt_left;
    logic [31:0] head;
    logic        found;
    rst = 1'b1;
    jump_flag_i = 1'b0; jump_addr_i = '0;
    int_flag_i = 1'b0;  int_addr_i = '0;
    hold_flag_i = 1'b0; dm_halt_req_i = 1'b0;
    ibus_gnt_i = 1'b0;  ibus_rvalid_i = 1'b0; ibus_rdata_i = '0;
    gnt_pct = 100; lat_min = 0; lat_max = 0; last_due = 0; idle_cnt = 0;
    prev_wait = 1'b0; prev_addr = '0;
    exp_issue = RESET_PC; exp_cons = RESET_PC;
    for (int i = 0; i < 3; i++) step();

    // Reset release with a 1-cycle bus: first instruction two cycles later.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) begin
        chk("first_req", 32'(s_req), 32'd1);
        chk("first_addr", s_addr, 32'h0);
      end
      if (i == 2 - BYP) begin
        chk("first_inst", s_inst, 32'h0000_0013);
        chk("first_inst_addr", s_iaddr, 32'h0);
      end
    end
    for (int i = 0; i < 8; i++) step();

    // Redirect latency with a 1-cycle bus.
    jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0300;
    step();
    jump_flag_i = 1'b0;
    step();
    chk("redir_req", 32'(s_req), 32'd1);
    chk("redir_addr", s_addr, 32'h0000_0300);
    step();
    if (BYP == 1) chk("redir_inst_addr_byp", s_iaddr, 32'h0000_0300);
    step();
    if (BYP == 0) chk("redir_inst_addr", s_iaddr, 32'h0000_0300);
    for (int i = 0; i < 6; i++) step();

    // Jump with two responses outstanding: both dropped.
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = (bus_addr_q.size() == 2);
    end
    chk("two_outstanding", 32'(bus_addr_q.size()), 32'd2);
    jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0100;
    step();
    jump_flag_i = 1'b0;
    cons_log.delete();
    for (int i = 0; i < 40 && cons_log.size() < 2; i++) step();
    chk("jump_cons_count", 32'(cons_log.size() >= 2), 32'd1);
    if (cons_log.size() >= 2) begin
      chk("jump_first", cons_log[0], 32'h0000_0100);
      chk("jump_second", cons_log[1], 32'h0000_0104);
    end
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 6; i++) step();

    // Interrupt wins over jump in the same cycle.
    int_flag_i = 1'b1; int_addr_i = 32'h0000_0080;
    jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0200;
    step();
    int_flag_i = 1'b0; jump_flag_i = 1'b0;
    step();
    chk("int_req", 32'(s_req), 32'd1);
    chk("int_addr", s_addr, 32'h0000_0080);
    for (int i = 0; i < 6; i++) step();

    // Hold with a full buffer: no issue, head frozen.
    hold_flag_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    head = s_iaddr;
    chk("hold_head_valid", 32'(s_inst != NOP), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_no_req", 32'(s_req), 32'd0);
      chk("hold_head", s_iaddr, head);
    end
    hold_flag_i = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Debug halt: no issue, NOP presented; resumes in order afterwards.
    dm_halt_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_no_req", 32'(s_req), 32'd0);
    end
    dm_halt_req_i = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // PC wrap from FFFF_FFFC to 0.
    jump_flag_i = 1'b1; jump_addr_i = 32'hFFFF_FFF8;
    step();
    jump_flag_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = s_req && ibus_gnt_i && (s_addr == 32'hFFFF_FFFC);
    end
    chk("wrap_seen", 32'(found), 32'd1);
    step();
    chk("wrap_addr", s_addr, 32'h0);
    for (int i = 0; i < 8; i++) step();

    // Randomized run.
    gnt_pct = 70; lat_min = 0; lat_max = 3; halt_left = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(999) < 3);
      jump_flag_i = ($urandom_range(99) < 3);
      int_flag_i  = ($urandom_range(99) < 2);
      jump_addr_i = ($urandom_range(9) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      int_addr_i  = $urandom & 32'hFFFF_FFFC;
      hold_flag_i = ($urandom_range(99) < 25);
      if (halt_left > 0) halt_left--;
      else if ($urandom_range(99) < 2) halt_left = $urandom_range(5, 1);
      dm_halt_req_i = (halt_left > 0);
      step();
    end
    rst = 1'b0; jump_flag_i = 1'b0; int_flag_i = 1'b0;
    hold_flag_i = 1'b0; dm_halt_req_i = 1'b0;
    for (int i = 0; i < 20; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
